// File: rtl/float_to_fixed_sp.sv
// float_to_fixed_sp: IEEE-754 single precision to signed Q(32-F).F fixed point.
// Three register stages (unpack/classify, align, sign/saturate). One word per clock,
// truncation toward zero, saturation on overflow, exception flags alongside the word.
module float_to_fixed_sp #(
    parameter int p_FRAC_BITS = 0
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_VALID,
    input  logic [31:0] i_FLOAT_WORD,
    output logic        o_VALID,
    output logic [31:0] o_FIXED_WORD,
    output logic        o_INVALID,
    output logic        o_OVERFLOW,
    output logic        o_INEXACT
);

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } cls_t;

    localparam logic signed [9:0] FRAC_S = 10'(p_FRAC_BITS);

    // Saturation value for an out-of-range magnitude of the given sign.
    function automatic logic [31:0] f_saturate(input logic sign);
        return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    // Two's-complement negation of the magnitude when the input was negative.
    function automatic logic [31:0] f_apply_sign(input logic sign, input logic [31:0] mag);
        return sign ? (~mag + 32'd1) : mag;
    endfunction

    // ---------------- stage 1: unpack / classify ----------------
    logic               vld_p1_q,    vld_p1_d;
    logic               sign_p1_q,   sign_p1_d;
    logic [22:0]        mant_p1_q,   mant_p1_d;
    logic signed [9:0]  shift_p1_q,  shift_p1_d;
    cls_t               cls_p1_q,    cls_p1_d;
    logic               denorm_p1_q, denorm_p1_d;

    // Split the float word, bias-correct the exponent and classify special encodings.
    always_comb begin
        logic [7:0] exp_v;
        exp_v       = i_FLOAT_WORD[30:23];
        vld_p1_d    = i_VALID;
        sign_p1_d   = i_FLOAT_WORD[31];
        mant_p1_d   = i_FLOAT_WORD[22:0];
        shift_p1_d  = $signed({2'b00, exp_v}) - 10'sd127 + FRAC_S;
        denorm_p1_d = (exp_v == 8'd0) && (mant_p1_d != 23'd0);
        cls_p1_d    = CLS_NORMAL;
        if (exp_v == 8'hFF) begin
            cls_p1_d = (mant_p1_d != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (exp_v == 8'd0) begin
            cls_p1_d = CLS_ZERO;
        end
    end

    // ---------------- stage 2: align ----------------
    logic        vld_p2_q,  vld_p2_d;
    logic        sign_p2_q, sign_p2_d;
    logic [31:0] mag_p2_q,  mag_p2_d;
    logic        inv_p2_q,  inv_p2_d;
    logic        ovf_p2_q,  ovf_p2_d;
    logic        inx_p2_q,  inx_p2_d;

    // Shift the hidden-one significand into integer position and flag lost bits.
    always_comb begin
        logic [31:0] w_v;
        logic [4:0]  rsh_v;
        w_v       = {1'b1, mant_p1_q, 8'b0};
        rsh_v     = 5'd31 - shift_p1_q[4:0];
        vld_p2_d  = vld_p1_q;
        sign_p2_d = sign_p1_q;
        mag_p2_d  = 32'd0;
        inv_p2_d  = 1'b0;
        ovf_p2_d  = 1'b0;
        inx_p2_d  = 1'b0;
        case (cls_p1_q)
            CLS_NAN:  inv_p2_d = 1'b1;
            CLS_INF:  ovf_p2_d = 1'b1;
            CLS_ZERO: inx_p2_d = denorm_p1_q;
            default: begin
                if (shift_p1_q < 10'sd0) begin
                    inx_p2_d = 1'b1;
                end else if (shift_p1_q <= 10'sd30) begin
                    mag_p2_d = w_v >> rsh_v;
                    inx_p2_d = |(w_v & ~(32'hFFFF_FFFF << rsh_v));
                end else if ((shift_p1_q == 10'sd31) && sign_p1_q && (mant_p1_q == 23'd0)) begin
                    // Exactly -2^31 is representable even though +2^31 is not.
                    mag_p2_d = 32'h8000_0000;
                end else begin
                    ovf_p2_d = 1'b1;
                end
            end
        endcase
    end

    // ---------------- stage 3: sign / saturate ----------------
    logic        vld_p3_q,   vld_p3_d;
    logic [31:0] fixed_p3_q, fixed_p3_d;
    logic        inv_p3_q,   inv_p3_d;
    logic        ovf_p3_q,   ovf_p3_d;
    logic        inx_p3_q,   inx_p3_d;

    // Produce the final word; an overflow or NaN suppresses the inexact flag.
    always_comb begin
        vld_p3_d   = vld_p2_q;
        inv_p3_d   = 1'b0;
        ovf_p3_d   = 1'b0;
        inx_p3_d   = 1'b0;
        fixed_p3_d = 32'd0;
        if (inv_p2_q) begin
            inv_p3_d = 1'b1;
        end else if (ovf_p2_q) begin
            ovf_p3_d   = 1'b1;
            fixed_p3_d = f_saturate(sign_p2_q);
        end else begin
            inx_p3_d   = inx_p2_q;
            fixed_p3_d = f_apply_sign(sign_p2_q, mag_p2_q);
        end
    end

    // Pipeline registers: all advance every cycle and clear immediately on reset.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            vld_p1_q    <= 1'b0;
            sign_p1_q   <= 1'b0;
            mant_p1_q   <= 23'd0;
            shift_p1_q  <= 10'sd0;
            cls_p1_q    <= CLS_NORMAL;
            denorm_p1_q <= 1'b0;
            vld_p2_q    <= 1'b0;
            sign_p2_q   <= 1'b0;
            mag_p2_q    <= 32'd0;
            inv_p2_q    <= 1'b0;
            ovf_p2_q    <= 1'b0;
            inx_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            fixed_p3_q  <= 32'd0;
            inv_p3_q    <= 1'b0;
            ovf_p3_q    <= 1'b0;
            inx_p3_q    <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            sign_p1_q   <= sign_p1_d;
            mant_p1_q   <= mant_p1_d;
            shift_p1_q  <= shift_p1_d;
            cls_p1_q    <= cls_p1_d;
            denorm_p1_q <= denorm_p1_d;
            vld_p2_q    <= vld_p2_d;
            sign_p2_q   <= sign_p2_d;
            mag_p2_q    <= mag_p2_d;
            inv_p2_q    <= inv_p2_d;
            ovf_p2_q    <= ovf_p2_d;
            inx_p2_q    <= inx_p2_d;
            vld_p3_q    <= vld_p3_d;
            fixed_p3_q  <= fixed_p3_d;
            inv_p3_q    <= inv_p3_d;
            ovf_p3_q    <= ovf_p3_d;
            inx_p3_q    <= inx_p3_d;
        end
    end

    assign o_VALID      = vld_p3_q;
    assign o_FIXED_WORD = fixed_p3_q;
    assign o_INVALID    = inv_p3_q;
    assign o_OVERFLOW   = ovf_p3_q;
    assign o_INEXACT    = inx_p3_q;

endmodule

// File: tb/tb_float_to_fixed_sp.sv
// Bench for float_to_fixed_sp: two instances (F=0 and F=16) fed from directed tables and
// random words, with queued expectations checked when each output valid appears.
module tb_float_to_fixed_sp;

    typedef struct packed {
        logic [31:0] word;
        logic        inv;
        logic        ovf;
        logic        inx;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld0 = 1'b0, vld16 = 1'b0;
    logic [31:0] in0 = 32'd0, in16 = 32'd0;
    logic        ov0, inv0, ovf0, inx0;
    logic        ov16, inv16, ovf16, inx16;
    logic [31:0] out0, out16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    sb_t q0[$];
    sb_t q16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_to_fixed_sp #(.p_FRAC_BITS(0)) dut0 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(vld0), .i_FLOAT_WORD(in0),
        .o_VALID(ov0), .o_FIXED_WORD(out0), .o_INVALID(inv0),
        .o_OVERFLOW(ovf0), .o_INEXACT(inx0)
    );

    float_to_fixed_sp #(.p_FRAC_BITS(16)) dut16 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(vld16), .i_FLOAT_WORD(in16),
        .o_VALID(ov16), .o_FIXED_WORD(out16), .o_INVALID(inv16),
        .o_OVERFLOW(ovf16), .o_INEXACT(inx16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference conversion using exact integer scaling of the 24-bit significand.
    function automatic res_t model(input logic [31:0] w, input int f);
        res_t r;
        logic        s;
        int          e, sh, n;
        longint unsigned full, mag, lim;
        bit big;
        s = w[31];
        e = int'(w[30:23]);
        r = '0;
        big = 1'b0;
        mag = 0;
        if (e == 255) begin
            if (w[22:0] != 0) begin
                r.inv = 1'b1;
                return r;
            end
            big = 1'b1;
        end else if (e == 0) begin
            r.inx = (w[22:0] != 0);
            return r;
        end else begin
            full = {40'd0, 1'b1, w[22:0]};
            sh = e - 150 + f;
            if (sh >= 0) begin
                if (sh > 40) big = 1'b1;
                else mag = full << sh;
            end else begin
                n = -sh;
                if (n >= 30) begin
                    mag = 0;
                    r.inx = 1'b1;
                end else begin
                    mag = full >> n;
                    r.inx = ((mag << n) != full);
                end
            end
        end
        lim = s ? 64'h8000_0000 : 64'h7FFF_FFFF;
        if (big || mag > lim) begin
            r.ovf  = 1'b1;
            r.inx  = 1'b0;
            r.word = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r.word = s ? (32'd0 - mag[31:0]) : mag[31:0];
        end
        return r;
    endfunction

    // One clock of stimulus: optional word on each instance, expectation queued with its cycle.
    task automatic drive(input bit v0, input logic [31:0] w0, input res_t e0,
                         input bit v16, input logic [31:0] w16, input res_t e16);
        sb_t ent;
        vld0 = v0;  in0 = w0;
        vld16 = v16; in16 = w16;
        if (v0) begin
            ent.r = e0; ent.cyc = cyc; q0.push_back(ent);
        end
        if (v16) begin
            ent.r = e16; ent.cyc = cyc; q16.push_back(ent);
        end
        @(posedge clk);
        #1;
        vld0 = 1'b0;
        vld16 = 1'b0;
    endtask

    task automatic send0(input logic [31:0] w, input res_t e);
        drive(1'b1, w, e, 1'b0, 32'd0, '0);
    endtask

    task automatic send16(input logic [31:0] w, input res_t e);
        drive(1'b0, 32'd0, '0, 1'b1, w, e);
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, '0, 1'b0, 32'd0, '0);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        sb_t ent;
        if (rst_n) begin
            if (ov0) begin
                if (q0.size() == 0) begin
                    chk("f0_unexpected_valid", 64'(ov0), 64'd0);
                end else begin
                    ent = q0.pop_front();
                    chk("f0_result", 64'({out0, inv0, ovf0, inx0}), 64'(ent.r));
                    chk("f0_latency", 64'(cyc - ent.cyc), 64'd3);
                end
            end
            if (ov16) begin
                if (q16.size() == 0) begin
                    chk("f16_unexpected_valid", 64'(ov16), 64'd0);
                end else begin
                    ent = q16.pop_front();
                    chk("f16_result", 64'({out16, inv16, ovf16, inx16}), 64'(ent.r));
                    chk("f16_latency", 64'(cyc - ent.cyc), 64'd3);
                end
            end
        end
    end

    logic [31:0] dir_w [12] = '{32'h3F80_0000, 32'h0000_0000, 32'h8000_0000, 32'hC020_0000,
                               32'h3F00_0000, 32'h0000_0001, 32'h4F00_0000, 32'hCF00_0000,
                               32'hCF00_0001, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000};
    res_t        dir_e [12] = '{{32'h0000_0001, 3'b000}, {32'h0000_0000, 3'b000},
                               {32'h0000_0000, 3'b000}, {32'hFFFF_FFFE, 3'b001},
                               {32'h0000_0000, 3'b001}, {32'h0000_0000, 3'b001},
                               {32'h7FFF_FFFF, 3'b010}, {32'h8000_0000, 3'b000},
                               {32'h8000_0000, 3'b010}, {32'h0000_0000, 3'b100},
                               {32'h7FFF_FFFF, 3'b010}, {32'h8000_0000, 3'b010}};

    initial begin
        logic [31:0] w;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'({ov0, ov16}), 64'd0);
        chk("reset_word", 64'({out0, out16}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed F=0 table, back to back
        for (int i = 0; i < 12; i++) send0(dir_w[i], dir_e[i]);
        repeat (4) idle();

        // F=16 cases
        send16(32'h3FC0_0000, '{32'h0001_8000, 1'b0, 1'b0, 1'b0});
        send16(32'h4700_0000, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        idle();

        // Back-to-back with a gap
        send0(32'h3F80_0000, '{32'd1, 1'b0, 1'b0, 1'b0});
        send0(32'h4000_0000, '{32'd2, 1'b0, 1'b0, 1'b0});
        idle();
        send0(32'h4040_0000, '{32'd3, 1'b0, 1'b0, 1'b0});
        repeat (4) idle();

        // Random words, concentrated around the interesting exponent range
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            if (i % 3 != 0) w[30:23] = 8'($urandom_range(110, 165));
            drive(1'b1, w, model(w, 0), 1'b1, w, model(w, 16));
        end
        repeat (4) idle();

        // Reset with two words in flight
        send0(32'h4000_0000, '{32'd2, 1'b0, 1'b0, 1'b0});
        send0(32'h4040_0000, '{32'd3, 1'b0, 1'b0, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(ov0), 64'd0);
        chk("async_reset_word", 64'(out0), 64'd0);
        q0.delete();
        q16.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) idle();

        // Post-reset conversion still works
        send0(32'hC020_0000, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});
        repeat (5) idle();

        chk("drain_f0", 64'(q0.size()), 64'd0);
        chk("drain_f16", 64'(q16.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
